// File: rtl/fp_result_packer.sv
// Final FPU output stage: classifies normaliser results, substitutes NaN/inf/max-finite/denormal
// values and packs them into an IEEE-754-style word behind a two-stage valid/ready pipeline.
module fp_result_packer #(
   parameter int unsigned EXP_W = 8,
   parameter int unsigned MAN_W = 23,
   parameter int unsigned SH_W  = $clog2(MAN_W + 2)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     in_sign,
   input  logic [MAN_W-1:0]         in_man,
   input  logic [EXP_W-1:0]         in_exp,
   input  logic [SH_W-1:0]          in_shift,
   input  logic                     in_ovf,
   input  logic                     in_unf,
   input  logic                     in_inv,
   input  logic [1:0]               rnd_mode,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [EXP_W+MAN_W:0]     out_result,
   output logic [3:0]               out_flags,
   input  logic                     flags_clr,
   output logic [3:0]               sticky_flags
);

   typedef enum logic [1:0] {
      CLS_NORM,
      CLS_UNF,
      CLS_OVF,
      CLS_INV
   } cls_e;

   typedef enum logic [1:0] {
      RM_RNE = 2'b00,
      RM_RTZ = 2'b01,
      RM_RUP = 2'b10,
      RM_RDN = 2'b11
   } rm_e;

   localparam logic [SH_W-1:0]  DEN_LIM = SH_W'(MAN_W + 1);
   localparam logic [EXP_W-1:0] MAXFIN_EXP = {{(EXP_W-1){1'b1}}, 1'b0};

   // Stage 1 registers
   logic              s1_valid_q;
   cls_e              s1_cls_q;
   rm_e               s1_rm_q;
   logic              s1_sign_q;
   logic [EXP_W-1:0]  s1_exp_q;
   logic [MAN_W-1:0]  s1_man_q;
   logic [SH_W-1:0]   s1_shift_q;

   // Stage 2 (output) registers
   logic                  out_valid_q;
   logic [EXP_W+MAN_W:0]  out_result_q;
   logic [3:0]            out_flags_q;
   logic [3:0]            sticky_q;

   logic                  s2_load;
   logic                  in_ready_w;
   logic                  out_hs;
   cls_e                  cls_d;

   logic [EXP_W+MAN_W:0]  res_d;
   logic [3:0]            flg_d;
   logic [3:0]            sticky_d;

   logic [SH_W-1:0]       den_sh;
   logic [MAN_W:0]        den_ext;
   logic [MAN_W:0]        den_lostmask;
   logic [MAN_W-1:0]      den_frac;
   logic                  den_nx;

   assign s2_load    = !out_valid_q || out_ready;
   assign in_ready_w = !s1_valid_q || s2_load;
   assign out_hs     = out_valid_q && out_ready;

   assign in_ready     = in_ready_w;
   assign out_valid    = out_valid_q;
   assign out_result   = out_result_q;
   assign out_flags    = out_flags_q;
   assign sticky_flags = sticky_q;

   // Highest-priority indication wins; the others are dropped here so their flags never appear.
   always_comb begin
      cls_d = CLS_NORM;
      if (in_inv) begin
         cls_d = CLS_INV;
      end else if (in_ovf) begin
         cls_d = CLS_OVF;
      end else if (in_unf) begin
         cls_d = CLS_UNF;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_cls_q   <= CLS_NORM;
         s1_rm_q    <= RM_RNE;
         s1_sign_q  <= 1'b0;
         s1_exp_q   <= '0;
         s1_man_q   <= '0;
         s1_shift_q <= '0;
      end else if (in_ready_w) begin
         s1_valid_q <= in_valid;
         if (in_valid) begin
            s1_cls_q   <= cls_d;
            s1_rm_q    <= rm_e'(rnd_mode);
            s1_sign_q  <= in_sign;
            s1_exp_q   <= in_exp;
            s1_man_q   <= in_man;
            s1_shift_q <= in_shift;
         end
      end
   end

   // Denormalisation: a zero shift still moves the hidden bit below the binary point.
   always_comb begin
      den_sh       = (s1_shift_q == '0) ? SH_W'(1) : s1_shift_q;
      den_ext      = {1'b1, s1_man_q};
      den_lostmask = ~({(MAN_W+1){1'b1}} << den_sh);
      den_frac     = MAN_W'(den_ext >> den_sh);
      den_nx       = |(den_ext & den_lostmask);
      if (den_sh >= DEN_LIM) begin
         den_frac = '0;
         den_nx   = 1'b1;
      end
   end

   always_comb begin
      res_d = {s1_sign_q, s1_exp_q, s1_man_q};
      flg_d = 4'b0000;
      unique case (s1_cls_q)
         CLS_INV: begin
            res_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            flg_d = 4'b1000;
         end
         CLS_OVF: begin
            flg_d = 4'b0101;
            unique case (s1_rm_q)
               RM_RNE: res_d = {s1_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
               RM_RTZ: res_d = {s1_sign_q, MAXFIN_EXP, {MAN_W{1'b1}}};
               RM_RUP: res_d = s1_sign_q ? {1'b1, MAXFIN_EXP, {MAN_W{1'b1}}}
                                         : {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
               RM_RDN: res_d = s1_sign_q ? {1'b1, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                                         : {1'b0, MAXFIN_EXP, {MAN_W{1'b1}}};
            endcase
         end
         CLS_UNF: begin
            res_d = {s1_sign_q, {EXP_W{1'b0}}, den_frac};
            flg_d = {2'b00, 1'b1, den_nx};
         end
         CLS_NORM: begin
            res_d = {s1_sign_q, s1_exp_q, s1_man_q};
            flg_d = 4'b0000;
         end
      endcase
   end

   // A clear coinciding with a handshake keeps only that result's flags.
   always_comb begin
      sticky_d = sticky_q;
      if (flags_clr) begin
         sticky_d = out_hs ? out_flags_q : 4'b0000;
      end else if (out_hs) begin
         sticky_d = sticky_q | out_flags_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q  <= 1'b0;
         out_result_q <= '0;
         out_flags_q  <= '0;
         sticky_q     <= '0;
      end else begin
         if (s2_load) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
               out_result_q <= res_d;
               out_flags_q  <= flg_d;
            end
         end
         sticky_q <= sticky_d;
      end
   end

endmodule

// File: tb/tb_fp_result_packer.sv
// Table-driven scoreboard bench for fp_result_packer with hand sequences for stall, sticky and reset.
module tb_fp_result_packer;

   typedef struct {
      logic        sign;
      logic [7:0]  exp;
      logic [22:0] man;
      logic [4:0]  sh;
      logic        ovf;
      logic        unf;
      logic        inv;
      logic [1:0]  rm;
      logic [31:0] er;
      logic [3:0]  ef;
   } vec_t;

   typedef struct {
      logic [31:0] r;
      logic [3:0]  f;
      int          tag;
   } sb_t;

   localparam int NV = 17;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic        in_sign;
   logic [22:0] in_man;
   logic [7:0]  in_exp;
   logic [4:0]  in_shift;
   logic        in_ovf;
   logic        in_unf;
   logic        in_inv;
   logic [1:0]  rnd_mode;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [3:0]  out_flags;
   logic        flags_clr;
   logic [3:0]  sticky_flags;

   int          n_cmp = 0;
   int          n_fail = 0;
   int          n_acc = 0;
   int          n_out = 0;
   vec_t        vecs[NV];
   sb_t         sb[$];
   sb_t         e_m;
   logic        hs_m;
   logic [3:0]  model_sticky = 4'b0000;
   logic [31:0] cur_er;
   logic [3:0]  cur_ef;
   int          cur_tag;
   bit          pass2_done;

   fp_result_packer #(.EXP_W(8), .MAN_W(23), .SH_W(5)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_sign(in_sign), .in_man(in_man), .in_exp(in_exp), .in_shift(in_shift),
      .in_ovf(in_ovf), .in_unf(in_unf), .in_inv(in_inv), .rnd_mode(rnd_mode),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_flags(out_flags),
      .flags_clr(flags_clr), .sticky_flags(sticky_flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mkv(input logic s, input logic [7:0] e, input logic [22:0] m,
                                input logic [4:0] sh, input logic o, input logic u, input logic i,
                                input logic [1:0] rm, input logic [31:0] er, input logic [3:0] ef);
      vec_t v;
      v.sign = s; v.exp = e; v.man = m; v.sh = sh;
      v.ovf = o; v.unf = u; v.inv = i; v.rm = rm;
      v.er = er; v.ef = ef;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [35:0] got, input logic [35:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   // Holds the word on the inputs until the DUT accepts it; called just after a rising edge.
   task automatic drive(input vec_t v, input int tag);
      int k = 0;
      bit acc = 1'b0;
      in_sign = v.sign; in_exp = v.exp; in_man = v.man; in_shift = v.sh;
      in_ovf = v.ovf; in_unf = v.unf; in_inv = v.inv; rnd_mode = v.rm;
      cur_er = v.er; cur_ef = v.ef; cur_tag = tag;
      in_valid = 1'b1;
      while (!acc) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk); #1;
         if (!acc) begin
            k++;
            if (k > 100) begin
               n_cmp++; n_fail++;
               $display("FAIL accept_timeout: tag %0d never accepted", tag);
               acc = 1'b1;
            end
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic drain(input string nm);
      int k = 0;
      while (sb.size() != 0 && k < 300) begin
         @(negedge clk);
         k++;
      end
      n_cmp++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL %s_drain: %0d words still pending, expected 0", nm, sb.size());
      end
      @(posedge clk); #1;
   endtask

   // Scoreboard: pop on output handshake, push on input handshake, track the sticky model.
   always @(negedge clk) begin
      n_cmp++;
      if (sticky_flags !== model_sticky) begin
         n_fail++;
         $display("FAIL sticky_track: got %b expected %b", sticky_flags, model_sticky);
      end
      if (rst) begin
         sb.delete();
         model_sticky = 4'b0000;
      end else begin
         hs_m = out_valid && out_ready;
         e_m.f = 4'b0000;
         if (hs_m) begin
            n_cmp++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_output: got %h/%b expected no word", out_result, out_flags);
            end else begin
               e_m = sb.pop_front();
               n_out++;
               if (out_result !== e_m.r || out_flags !== e_m.f) begin
                  n_fail++;
                  $display("FAIL vec%0d: got %h/%b expected %h/%b",
                           e_m.tag, out_result, out_flags, e_m.r, e_m.f);
               end
            end
         end
         if (flags_clr) model_sticky = hs_m ? e_m.f : 4'b0000;
         else if (hs_m) model_sticky = model_sticky | e_m.f;
         if (in_valid && in_ready) begin
            sb.push_back('{r: cur_er, f: cur_ef, tag: cur_tag});
            n_acc++;
         end
      end
   end

   initial begin
      int base;
      //              sign exp    man         sh     ovf  unf  inv  rm     result        flags
      vecs[0]  = mkv(1'b0, 8'h7F, 23'h400000, 5'd0,  1'b0,1'b0,1'b0,2'b00, 32'h3FC00000, 4'b0000);
      vecs[1]  = mkv(1'b1, 8'h10, 23'h000000, 5'd0,  1'b1,1'b0,1'b0,2'b00, 32'hFF800000, 4'b0101);
      vecs[2]  = mkv(1'b1, 8'h10, 23'h000000, 5'd0,  1'b1,1'b0,1'b0,2'b01, 32'hFF7FFFFF, 4'b0101);
      vecs[3]  = mkv(1'b1, 8'h10, 23'h000000, 5'd0,  1'b1,1'b0,1'b0,2'b10, 32'hFF7FFFFF, 4'b0101);
      vecs[4]  = mkv(1'b1, 8'h10, 23'h000000, 5'd0,  1'b1,1'b0,1'b0,2'b11, 32'hFF800000, 4'b0101);
      vecs[5]  = mkv(1'b0, 8'h10, 23'h000000, 5'd0,  1'b1,1'b0,1'b0,2'b10, 32'h7F800000, 4'b0101);
      vecs[6]  = mkv(1'b0, 8'h10, 23'h000000, 5'd0,  1'b1,1'b0,1'b0,2'b11, 32'h7F7FFFFF, 4'b0101);
      vecs[7]  = mkv(1'b1, 8'h55, 23'h123456, 5'd3,  1'b1,1'b1,1'b1,2'b01, 32'h7FC00000, 4'b1000);
      vecs[8]  = mkv(1'b0, 8'h00, 23'h000000, 5'd1,  1'b0,1'b1,1'b0,2'b00, 32'h00400000, 4'b0010);
      vecs[9]  = mkv(1'b0, 8'h00, 23'h000001, 5'd2,  1'b0,1'b1,1'b0,2'b00, 32'h00200000, 4'b0011);
      vecs[10] = mkv(1'b0, 8'h00, 23'h000000, 5'd0,  1'b0,1'b1,1'b0,2'b10, 32'h00400000, 4'b0010);
      vecs[11] = mkv(1'b0, 8'h00, 23'h000000, 5'd24, 1'b0,1'b1,1'b0,2'b00, 32'h00000000, 4'b0011);
      vecs[12] = mkv(1'b0, 8'h20, 23'h000000, 5'd0,  1'b1,1'b1,1'b0,2'b00, 32'h7F800000, 4'b0101);
      vecs[13] = mkv(1'b1, 8'h00, 23'h7FFFFF, 5'd23, 1'b0,1'b1,1'b0,2'b11, 32'h80000001, 4'b0011);
      vecs[14] = mkv(1'b1, 8'h00, 23'h7FFFFF, 5'd31, 1'b0,1'b1,1'b0,2'b00, 32'h80000000, 4'b0011);
      vecs[15] = mkv(1'b1, 8'h81, 23'h123456, 5'd9,  1'b0,1'b0,1'b0,2'b11, 32'hC0923456, 4'b0000);
      vecs[16] = mkv(1'b0, 8'h00, 23'h000001, 5'd1,  1'b0,1'b1,1'b0,2'b00, 32'h00400000, 4'b0011);

      rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_man = '0; in_exp = '0; in_shift = '0;
      in_ovf = 1'b0; in_unf = 1'b0; in_inv = 1'b0; rnd_mode = 2'b00;
      out_ready = 1'b1; flags_clr = 1'b0; pass2_done = 1'b0;
      cur_er = '0; cur_ef = '0; cur_tag = -1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_out_valid", 36'(out_valid), 36'd0);
      chk("reset_out_result", 36'(out_result), 36'd0);
      chk("reset_out_flags", 36'(out_flags), 36'd0);
      chk("reset_sticky", 36'(sticky_flags), 36'd0);
      chk("reset_in_ready", 36'(in_ready), 36'd1);
      @(posedge clk); #1;

      base = n_out;
      for (int i = 0; i < NV; i++) drive(vecs[i], i);
      drain("pass1");
      chk("pass1_count", 36'(n_out - base), 36'(NV));

      base = n_out;
      fork
         begin
            for (int i = 0; i < NV; i++) drive(vecs[NV-1-i], 100 + NV - 1 - i);
            pass2_done = 1'b1;
         end
         begin
            while (!pass2_done) begin
               @(posedge clk); #1;
               out_ready = 1'($urandom_range(0, 1));
            end
         end
      join
      out_ready = 1'b1;
      drain("pass2");
      chk("pass2_count", 36'(n_out - base), 36'(NV));

      // Backpressure: four words with the output blocked for five cycles.
      out_ready = 1'b0;
      base = n_acc;
      fork
         for (int i = 0; i < 4; i++) drive(vecs[i], 200 + i);
         begin
            int k = 0;
            while (n_acc < base + 2 && k < 50) begin
               @(negedge clk);
               k++;
            end
            @(posedge clk);
            for (int c = 0; c < 5; c++) begin
               @(negedge clk);
               chk("bp_in_ready_low", 36'(in_ready), 36'd0);
               chk("bp_out_valid", 36'(out_valid), 36'd1);
               chk("bp_stable_result", {out_flags, out_result}, {4'b0000, 32'h3FC00000});
               chk("bp_accepts", 36'(n_acc - base), 36'd2);
            end
            @(posedge clk); #1;
            out_ready = 1'b1;
         end
      join
      drain("bp");
      chk("bp_total_accepts", 36'(n_acc - base), 36'd4);

      // Sticky accumulation and clear.
      flags_clr = 1'b1;
      @(posedge clk); #1;
      flags_clr = 1'b0;
      chk("sticky_cleared", 36'(sticky_flags), 36'd0);
      drive(vecs[1], 300);
      drive(vecs[8], 301);
      drain("sticky");
      chk("sticky_ovf_unf", 36'(sticky_flags), 36'b0111);

      out_ready = 1'b0;
      drive(vecs[7], 302);
      begin
         int k = 0;
         while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
         end
         chk("inv_reached_output", 36'(out_valid), 36'd1);
      end
      @(posedge clk); #1;
      flags_clr = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      flags_clr = 1'b0;
      chk("sticky_clr_with_hs", 36'(sticky_flags), 36'b1000);

      // Reset with two words in flight.
      out_ready = 1'b0;
      drive(vecs[1], 400);
      drive(vecs[2], 401);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("midrst_out_valid", 36'(out_valid), 36'd0);
      chk("midrst_sticky", 36'(sticky_flags), 36'd0);
      chk("midrst_in_ready", 36'(in_ready), 36'd1);
      out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("midrst_no_output", 36'(out_valid), 36'd0);
      drive(vecs[0], 402);
      drain("post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/fp_result_packer.md
Name: fp_result_packer

Overview:
Parametrised, pipelined successor of the FPU final-output stage. It takes the normalised sign, exponent and mantissa plus the exception indications from the datapath. It applies special-case substitution (NaN, infinity or max-finite, denormalisation) under a selectable rounding mode and emits a packed IEEE-754-style word with per-result and sticky exception flags. It sits between the normaliser and the FPU result bus and uses valid/ready handshaking on both sides.

Parameters:
EXP_W, 8, exponent width.
MAN_W, 23, stored fraction width (hidden bit excluded).
SH_W, $clog2(MAN_W+2), width of the denormalisation shift amount.

Ports:
clk  in  1  clock.
rst  in  1  synchronous active-high reset.
in_valid  in  1  input word valid.
in_ready  out  1  block can accept an input this cycle.
in_sign  in  1  result sign.
in_man  in  MAN_W  normalised fraction.
in_exp  in  EXP_W  biased exponent.
in_shift  in  SH_W  denormalisation right-shift amount (used on underflow only).
in_ovf  in  1  overflow indication.
in_unf  in  1  underflow indication.
in_inv  in  1  invalid-operation indication.
rnd_mode  in  2  rounding mode: 00 RNE, 01 RTZ, 10 RUP (toward +inf), 11 RDN (toward -inf); sampled with the input.
out_valid  out  1  output word valid.
out_ready  in  1  downstream accepts the output.
out_result  out  1+EXP_W+MAN_W  packed word {sign, exp, frac}.
out_flags  out  4  {NV, OF, UF, NX} for out_result.
flags_clr  in  1  clear the sticky flags.
sticky_flags  out  4  OR of out_flags over all accepted results since the last clear.

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Pipeline: two register stages. S1 captures the inputs, classifies them and computes the special cases. S2 is the output register. Latency is 2 cycles from input handshake to out_valid with no stall.
- Advance conditions:
  - S2 loads when !out_valid || out_ready.
  - S1 advances when S2 loads.
  - in_ready = !s1_valid || s2_load.
- Handshake rules:
  - An input is accepted on in_valid && in_ready.
  - An output is consumed on out_valid && out_ready.
  - out_result and out_flags hold stable while out_valid && !out_ready.
  - Full throughput is 1 word/cycle.
  - Bubbles collapse: an empty S2 always loads.
- Priority, highest first: invalid > overflow > underflow > normal. Lower-priority indications are ignored and do not raise their flags.
- Invalid: result = sign 0, exp all ones, frac = 1 followed by zeros (canonical quiet NaN). Flags NV=1, others 0.
- Overflow: OF=1, NX=1. Result by rounding mode:
  - RNE: signed infinity (exp all ones, frac 0).
  - RTZ: signed max finite (exp all ones minus 1, frac all ones).
  - RUP: +inf if sign=0, else -max finite.
  - RDN: -inf if sign=1, else +max finite.
- Underflow: exp = 0, sign = in_sign, UF=1.
  - Let s = in_shift, treated as 1 when in_shift=0.
  - frac = low MAN_W bits of ({1'b1, in_man} >> s).
  - NX=1 if any bit shifted out is nonzero.
  - If s >= MAN_W+1, frac = 0 and NX=1.
  - Denormal results are truncated; the rounding mode is not applied.
- Normal: result = {in_sign, in_exp, in_man}, flags 0.
- Sticky flags:
  - On each output handshake, sticky_flags |= out_flags.
  - flags_clr zeroes sticky_flags. If a clear and a handshake occur in the same cycle, the result is that output's flags only.
  - flags_clr does not affect the pipeline.
- Reset values: out_valid=0, out_result=0, out_flags=0, sticky_flags=0; internal s1_valid=0, so in_ready=1 after reset. Reset mid-operation discards in-flight words, with out_valid=0 on the cycle after rst.

Test Plan:
- Normal pass-through: sign 0, exp 0x7F, man 0x400000, no flags -> 2 cycles later out_result=0x3FC00000, out_flags=0000.
- Overflow in every mode, sign 1: RNE -> 0xFF800000; RTZ -> 0xFF7FFFFF; RUP -> 0xFF7FFFFF; RDN -> 0xFF800000; each with flags {OF,NX}=0101.
- Priority: in_inv=in_ovf=in_unf=1 -> 0x7FC00000, flags 1000, sticky shows NV only.
- Underflow shifts:
  - man 0, shift 1 -> 0x00400000, flags 0010.
  - man 0x000001, shift 2 -> 0x00200000, flags 0011.
  - shift 0 -> same as shift 1.
  - shift 24 -> 0x00000000, flags 0011.
- Backpressure: stream 4 words, hold out_ready=0 for 5 cycles -> in_ready drops after 2 accepts; out_result stays stable; all 4 words emerge in order once ready=1, with no loss or duplication.
- Sticky and reset: overflow then underflow -> sticky=0111; flags_clr coincident with an invalid-result handshake -> sticky=1000; assert rst with 2 words in flight -> out_valid=0 next cycle, sticky=0, in_ready=1.
